secure_debug_trace: RTL and testbench
=====================================

// Module: secure_debug_trace
// PURPOSE
//  Parametrised, access-controlled debug trace port. Replaces the open single-register debug tap.
//  Registers NUM_CH data channels and captures one selected channel into a DEPTH-entry trace buffer.
//  Buffer contents are readable only after a key-based unlock. Repeated bad keys lock the port out until reset.
//  Sits between datapath registers and the debug/JTAG bridge.
// PARAMETERS
//  DATA_W   32            width of one channel / one trace entry
//  NUM_CH   2             number of data channels (>=1)
//  DEPTH    8             trace buffer entries (power of 2, >=2)
//  KEY_W    32            unlock key width
//  KEY      32'hA5A5_5A5A unlock key value
//  MAX_FAIL 3             wrong-key attempts before LOCKOUT (>=1)
// PORTS
//  clk           in   1                  clock, all logic on rising edge
//  rst_n         in   1                  asynchronous active-low reset
//  enable        in   1                  datapath update strobe
//  data_in       in   NUM_CH*DATA_W      channel data, ch k at [k*DATA_W +: DATA_W]
//  data_out      out  NUM_CH*DATA_W      registered channel data
//  trace_ch      in   $clog2(NUM_CH)+1   channel selected for capture
//  wrap_mode     in   1                  1: overwrite oldest when full; 0: drop new when full
//  unlock_valid  in   1                  unlock attempt strobe
//  unlock_key    in   KEY_W              key presented with unlock_valid
//  relock        in   1                  return to LOCKED and flush buffer
//  rd_req        in   1                  pop request from debug bridge
//  rd_valid      out  1                  debug_data valid (one-cycle pulse per pop)
//  debug_data    out  DATA_W             popped trace entry, 0 whenever rd_valid=0
//  level         out  $clog2(DEPTH+1)    entries held
//  overflow      out  1                  sticky: a capture hit a full buffer
//  dbg_state     out  2                  00 LOCKED, 01 UNLOCKED, 10 LOCKOUT
// BEHAVIOUR
//  Reset: data_out=0, rd_valid=0, debug_data=0, level=0, overflow=0, fail count=0, dbg_state=LOCKED.
//  Datapath: on enable, data_out <= data_in (1-cycle latency). Independent of debug state.
//  Capture: fires on enable && state==UNLOCKED && trace_ch<NUM_CH.
//   Pushes the pre-update data_out slice of trace_ch, i.e. the value held before this edge.
//   trace_ch>=NUM_CH: no push, no overflow.
//  Read: rd_req && state==UNLOCKED && level>0 pops the oldest entry. Next cycle rd_valid=1 and debug_data=entry.
//   rd_req when empty or not UNLOCKED: ignored, rd_valid=0.
//  Ordering in one cycle: pop is evaluated first, then push.
//   Simultaneous push+pop leaves level unchanged and never sets overflow.
//  Full (level==DEPTH) push without pop:
//   wrap_mode=1: drop oldest, store new, level stays DEPTH, overflow<=1.
//   wrap_mode=0: discard new, overflow<=1.
//  Pointers wrap modulo DEPTH. level saturates at DEPTH and never underflows.
//  FSM:
//   LOCKED: unlock_valid && key==KEY -> UNLOCKED, fail count<=0.
//    unlock_valid && key!=KEY increments fail count. Reaching MAX_FAIL -> LOCKOUT.
//   UNLOCKED: relock -> LOCKED. unlock_valid is ignored.
//   LOCKOUT: absorbing until rst_n. All unlock attempts are ignored.
//   relock and unlock_valid in the same cycle: relock wins, no fail counted.
//  Any exit from UNLOCKED flushes the buffer: level<=0, overflow<=0, pointers<=0.
//   A pending rd_valid is cancelled and debug_data<=0.
//  Reset asserted mid-operation clears everything asynchronously. Buffer RAM content is don't-care after reset.
// STRUCTURE
//  debug_pkg: state enum (DBG_LOCKED/DBG_UNLOCKED/DBG_LOCKOUT) and the 2-bit state width.
//  One sub-module, dbg_trace_fifo:
//   params DATA_W and DEPTH; inputs push, pop, wrap, flush; outputs rd_data, level, full, empty, ovf.
//  Top level holds the channel registers, the unlock FSM, the fail counter and the output masking.
// TESTING
//  1 Reset, no unlock. enable=1, data_in ch0=0x11, rd_req=1 -> data_out ch0=0x11; level=0, rd_valid=0, debug_data=0.
//  2 Unlock with 0xA5A55A5A, trace_ch=0, feed ch0 0x1..0x4 on 4 enables, then 4 rd_req
//    -> rd_valid pulses with 0x0,0x1,0x2,0x3 (pre-update values), level ends at 0.
//  3 Unlocked, wrap_mode=1, 10 captures of 0x10..0x19 (DEPTH=8) -> overflow=1, level=8, reads return the newest 8 values in order.
//    Repeat with wrap_mode=0 -> reads return the first 8 values.
//  4 Three unlock_valid with key 0x0 -> dbg_state=LOCKOUT. Correct key then -> still LOCKOUT. rst_n pulse -> LOCKED.
//  5 Unlocked, level=5, relock+unlock_valid same cycle -> LOCKED, level=0, overflow=0, fail count unchanged.
//  6 Full buffer, wrap_mode=0, push+pop same cycle -> level stays 8, overflow stays 0.
//    Also assert rst_n low mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/secure_debug_trace_pkg.sv
// Shared constants for the secure debug trace port: unlock FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Ports: none. The state encoding is visible on dbg_state, so it must stay stable.
package secure_debug_trace_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] DBG_LOCKED   = 2'b00;
    localparam logic [STATE_W-1:0] DBG_UNLOCKED = 2'b01;
    localparam logic [STATE_W-1:0] DBG_LOCKOUT  = 2'b10;

endpackage

// File: rtl/secure_debug_trace_if.sv
// Debug/JTAG bridge side of the trace port: unlock, relock, pop and status.
// Latency: n/a (wiring only).
// Backpressure: none; the bridge pops with rd_req and sees a one-cycle rd_valid pulse.
// master: bridge (drives unlock_valid/unlock_key/relock/rd_req); slave: trace port.
interface secure_debug_trace_if #(
    parameter int DATA_W = 32,
    parameter int KEY_W  = 32,
    parameter int DEPTH  = 8
);
    import secure_debug_trace_pkg::*;

    logic                         unlock_valid;
    logic [KEY_W-1:0]             unlock_key;
    logic                         relock;
    logic                         rd_req;
    logic                         rd_valid;
    logic [DATA_W-1:0]            debug_data;
    logic [$clog2(DEPTH+1)-1:0]   level;
    logic                         overflow;
    logic [STATE_W-1:0]           dbg_state;

    modport master (
        output unlock_valid, unlock_key, relock, rd_req,
        input  rd_valid, debug_data, level, overflow, dbg_state
    );

    modport slave (
        input  unlock_valid, unlock_key, relock, rd_req,
        output rd_valid, debug_data, level, overflow, dbg_state
    );

endinterface

// File: rtl/secure_debug_trace_fifo.sv
// Trace buffer: DEPTH-entry FIFO with optional overwrite-oldest when full and a sticky overflow flag.
// Latency: rd_data shows the oldest entry combinationally; push/pop take effect on the next edge.
// Backpressure: none; a push into a full buffer either evicts the oldest entry (wrap) or is dropped.
// Ports: push/pop/wrap/flush in, wr_data in; rd_data, level, full, empty, ovf out.
module dbg_trace_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       wrap,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              do_pop;
    logic              do_push;
    logic              drop_old;

    assign full    = (level == ($clog2(DEPTH+1))'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rptr];

    // Pop is resolved before push, so a pop from a full buffer frees the slot the push needs.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop || wrap);
    assign drop_old = push && full && !do_pop && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop || drop_old) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop && !full) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
            if (push && full && !do_pop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= wr_data;
        end
    end

endmodule

// File: rtl/secure_debug_trace.sv
// Access-controlled debug trace port: registers NUM_CH channels, traces one into a key-protected buffer.
// Latency: data_out 1 cycle after enable; debug_data/rd_valid 1 cycle after an accepted rd_req.
// Backpressure: none; rd_req is ignored when empty or not unlocked, captures follow wrap_mode when full.
// Ports: clk, rst_n, enable, data_in, data_out, trace_ch, wrap_mode; dbg (slave) carries the bridge side.
module secure_debug_trace
    import secure_debug_trace_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               NUM_CH   = 2,
    parameter int               DEPTH    = 8,
    parameter int               KEY_W    = 32,
    parameter logic [KEY_W-1:0] KEY      = 32'hA5A5_5A5A,
    parameter int               MAX_FAIL = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_CH*DATA_W-1:0]   data_in,
    output logic [NUM_CH*DATA_W-1:0]   data_out,
    input  logic [$clog2(NUM_CH):0]    trace_ch,
    input  logic                       wrap_mode,
    secure_debug_trace_if.slave        dbg
);
    localparam int CH_W   = $clog2(NUM_CH) + 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic [STATE_W-1:0]         state_q;
    logic [STATE_W-1:0]         state_d;
    logic [FAIL_W-1:0]          fail_q;
    logic [FAIL_W-1:0]          fail_d;
    logic                       unlocked;
    logic                       flush;
    logic                       push;
    logic                       pop;
    logic [DATA_W-1:0]          cap_dat;
    logic [DATA_W-1:0]          fifo_rd;
    logic [$clog2(DEPTH+1)-1:0] fifo_level;
    logic                       fifo_empty;
    logic                       fifo_ovf;
    logic                       rd_valid_q;
    logic [DATA_W-1:0]          debug_data_q;

    assign unlocked = (state_q == DBG_UNLOCKED);
    // Leaving UNLOCKED is the only way out of it, so this is also the buffer flush.
    assign flush    = unlocked && dbg.relock;
    assign push     = enable && unlocked && (trace_ch < CH_W'(NUM_CH));
    assign pop      = dbg.rd_req && unlocked && !fifo_empty;

    // Capture the value held before this edge, not the incoming data_in.
    always_comb begin
        cap_dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (trace_ch == CH_W'(k)) begin
                cap_dat = data_out[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        case (state_q)
            DBG_LOCKED: begin
                // relock alongside an attempt cancels the attempt, so no fail is counted.
                if (dbg.unlock_valid && !dbg.relock) begin
                    if (dbg.unlock_key == KEY) begin
                        state_d = DBG_UNLOCKED;
                        fail_d  = '0;
                    end else if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
                        state_d = DBG_LOCKOUT;
                        fail_d  = FAIL_W'(MAX_FAIL);
                    end else begin
                        fail_d = fail_q + 1'b1;
                    end
                end
            end
            DBG_UNLOCKED: begin
                if (dbg.relock) begin
                    state_d = DBG_LOCKED;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DBG_LOCKED;
            fail_q       <= '0;
            data_out     <= '0;
            rd_valid_q   <= 1'b0;
            debug_data_q <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            if (enable) begin
                data_out <= data_in;
            end
            rd_valid_q   <= pop && !flush;
            debug_data_q <= (pop && !flush) ? fifo_rd : '0;
        end
    end

    dbg_trace_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wrap    (wrap_mode),
        .flush   (flush),
        .wr_data (cap_dat),
        .rd_data (fifo_rd),
        .level   (fifo_level),
        .full    (),
        .empty   (fifo_empty),
        .ovf     (fifo_ovf)
    );

    assign dbg.rd_valid   = rd_valid_q;
    assign dbg.debug_data = debug_data_q;
    assign dbg.level      = fifo_level;
    assign dbg.overflow   = fifo_ovf;
    assign dbg.dbg_state  = state_q;

endmodule

// File: tb/tb_secure_debug_trace.sv
// Bench for secure_debug_trace: vector table, directed corner sequences, randomized run vs queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_secure_debug_trace;
    localparam int          NUM_CH   = 2;
    localparam int          DEPTH    = 8;
    localparam int          MAX_FAIL = 3;
    localparam logic [31:0] KEY      = 32'hA5A5_5A5A;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic [1:0]  trace_ch;
    logic        wrap_mode;

    secure_debug_trace_if #(.DATA_W(32), .KEY_W(32), .DEPTH(8)) dbg ();

    secure_debug_trace dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .data_in   (data_in),
        .data_out  (data_out),
        .trace_ch  (trace_ch),
        .wrap_mode (wrap_mode),
        .dbg       (dbg)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable           = 1'b0;
        dbg.unlock_valid = 1'b0;
        dbg.unlock_key   = '0;
        dbg.relock       = 1'b0;
        dbg.rd_req       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic unlock_now();
        enable           = 1'b0;
        dbg.unlock_valid = 1'b1;
        dbg.unlock_key   = KEY;
        tick();
        dbg.unlock_valid = 1'b0;
    endtask

    // ---------------- reference model: a plain queue plus the access rules ----------------
    logic [31:0] mq[$];
    logic [31:0] m_data[2];
    int          m_state;
    int          m_fail;
    logic        m_ovf;
    logic        m_rv;
    logic [31:0] m_dd;

    function automatic void model_reset();
        mq.delete();
        m_data[0] = '0;
        m_data[1] = '0;
        m_state   = 0;
        m_fail    = 0;
        m_ovf     = 1'b0;
        m_rv      = 1'b0;
        m_dd      = '0;
    endfunction

    function automatic void model_edge();
        m_rv = 1'b0;
        m_dd = '0;
        if (m_state == 1 && dbg.relock) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_state = 0;
        end else if (m_state == 1) begin
            if (dbg.rd_req && mq.size() > 0) begin
                m_rv = 1'b1;
                m_dd = mq.pop_front();
            end
            if (enable && trace_ch < NUM_CH) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(m_data[trace_ch[0]]);
                end else begin
                    m_ovf = 1'b1;
                    if (wrap_mode) begin
                        void'(mq.pop_front());
                        mq.push_back(m_data[trace_ch[0]]);
                    end
                end
            end
        end else if (m_state == 0 && dbg.unlock_valid && !dbg.relock) begin
            if (dbg.unlock_key == KEY) begin
                m_state = 1;
                m_fail  = 0;
            end else begin
                m_fail++;
                if (m_fail >= MAX_FAIL) m_state = 2;
            end
        end
        if (enable) begin
            m_data[0] = data_in[31:0];
            m_data[1] = data_in[63:32];
        end
    endfunction

    task automatic compare_model();
        chk("rnd data_out", data_out, {m_data[1], m_data[0]});
        chk("rnd rd_valid", dbg.rd_valid, m_rv);
        chk("rnd debug_data", dbg.debug_data, m_dd);
        chk("rnd level", dbg.level, mq.size());
        chk("rnd overflow", dbg.overflow, m_ovf);
        chk("rnd dbg_state", dbg.dbg_state, m_state);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  tc;
        logic        uv;
        logic [31:0] key;
        logic        rl;
        logic        rd;
        logic [31:0] e_d0;
        logic        e_rv;
        logic [31:0] e_dd;
        int          e_lvl;
        logic [1:0]  e_st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic [31:0] d0, logic [31:0] d1, logic [1:0] tc,
                                logic uv, logic [31:0] key, logic rl, logic rd,
                                logic [31:0] e_d0, logic e_rv, logic [31:0] e_dd, int e_lvl,
                                logic [1:0] e_st);
        vec_t v;
        v.en = en; v.d0 = d0; v.d1 = d1; v.tc = tc; v.uv = uv; v.key = key; v.rl = rl; v.rd = rd;
        v.e_d0 = e_d0; v.e_rv = e_rv; v.e_dd = e_dd; v.e_lvl = e_lvl; v.e_st = e_st;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        data_in   = '0;
        trace_ch  = '0;
        wrap_mode = 1'b0;
        #2;
        chk("reset data_out", data_out, 64'h0);
        chk("reset rd_valid", dbg.rd_valid, 1'b0);
        chk("reset debug_data", dbg.debug_data, 32'h0);
        chk("reset level", dbg.level, 4'd0);
        chk("reset overflow", dbg.overflow, 1'b0);
        chk("reset dbg_state", dbg.dbg_state, 2'b00);
        #5;
        rst_n = 1'b1;

        //      en d0      d1      tc uv key      rl rd   e_d0   rv e_dd   lvl st
        tbl.push_back(mk(1, 32'h11, 32'h22, 0, 0, 32'h0, 0, 1, 32'h11, 0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 32'h00, 32'h22, 0, 1, KEY,   0, 0, 32'h00, 0, 32'h0, 0, 1));
        tbl.push_back(mk(1, 32'h01, 32'h22, 0, 0, 32'h0, 0, 0, 32'h01, 0, 32'h0, 1, 1));
        tbl.push_back(mk(1, 32'h02, 32'h22, 0, 0, 32'h0, 0, 0, 32'h02, 0, 32'h0, 2, 1));
        tbl.push_back(mk(1, 32'h03, 32'h22, 0, 0, 32'h0, 0, 0, 32'h03, 0, 32'h0, 3, 1));
        tbl.push_back(mk(1, 32'h04, 32'h22, 0, 0, 32'h0, 0, 0, 32'h04, 0, 32'h0, 4, 1));
        tbl.push_back(mk(0, 32'h04, 32'h22, 0, 0, 32'h0, 0, 1, 32'h04, 1, 32'h0, 3, 1));
        tbl.push_back(mk(0, 32'h04, 32'h22, 0, 0, 32'h0, 0, 1, 32'h04, 1, 32'h1, 2, 1));
        tbl.push_back(mk(0, 32'h04, 32'h22, 0, 0, 32'h0, 0, 1, 32'h04, 1, 32'h2, 1, 1));
        tbl.push_back(mk(0, 32'h04, 32'h22, 0, 0, 32'h0, 0, 1, 32'h04, 1, 32'h3, 0, 1));
        tbl.push_back(mk(0, 32'h04, 32'h22, 0, 0, 32'h0, 0, 1, 32'h04, 0, 32'h0, 0, 1));
        tbl.push_back(mk(1, 32'h05, 32'h22, 2, 0, 32'h0, 0, 0, 32'h05, 0, 32'h0, 0, 1));
        tbl.push_back(mk(1, 32'h05, 32'h77, 1, 0, 32'h0, 0, 0, 32'h05, 0, 32'h0, 1, 1));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 0, 32'h0, 0, 1, 32'h05, 1, 32'h22, 0, 1));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, KEY,   1, 0, 32'h05, 0, 32'h0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, 32'h0, 1, 0, 32'h05, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, 32'h0, 0, 0, 32'h05, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, 32'h0, 0, 0, 32'h05, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, KEY,   0, 0, 32'h05, 0, 32'h0, 0, 1));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, 32'h0, 0, 0, 32'h05, 0, 32'h0, 0, 1));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, 32'h0, 0, 0, 32'h05, 0, 32'h0, 0, 1));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 0, 32'h0, 1, 0, 32'h05, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, 32'h0, 0, 0, 32'h05, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, 32'h0, 0, 0, 32'h05, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, 32'h0, 0, 0, 32'h05, 0, 32'h0, 0, 2));
        tbl.push_back(mk(0, 32'h05, 32'h77, 0, 1, KEY,   0, 0, 32'h05, 0, 32'h0, 0, 2));

        tick();
        for (int i = 0; i < tbl.size(); i++) begin
            enable           = tbl[i].en;
            data_in          = {tbl[i].d1, tbl[i].d0};
            trace_ch         = tbl[i].tc;
            dbg.unlock_valid = tbl[i].uv;
            dbg.unlock_key   = tbl[i].key;
            dbg.relock       = tbl[i].rl;
            dbg.rd_req       = tbl[i].rd;
            tick();
            chk($sformatf("vec%0d data_out0", i), data_out[31:0], tbl[i].e_d0);
            chk($sformatf("vec%0d rd_valid", i), dbg.rd_valid, tbl[i].e_rv);
            chk($sformatf("vec%0d debug_data", i), dbg.debug_data, tbl[i].e_dd);
            chk($sformatf("vec%0d level", i), dbg.level, tbl[i].e_lvl);
            chk($sformatf("vec%0d dbg_state", i), dbg.dbg_state, tbl[i].e_st);
        end

        // Lockout is left only by reset; the fail count restarts from zero.
        do_reset();
        tick();
        chk("lockout reset state", dbg.dbg_state, 2'b00);
        unlock_now();
        chk("unlock after reset", dbg.dbg_state, 2'b01);

        // Overflow with overwrite-oldest, then with drop-new.
        for (int w = 1; w >= 0; w--) begin
            do_reset();
            enable = 1'b1; data_in = 64'h10; trace_ch = 0;
            tick();
            unlock_now();
            wrap_mode = w[0];
            for (int i = 0; i < 10; i++) begin
                enable = 1'b1;
                data_in[31:0] = 32'h11 + i;
                tick();
            end
            enable = 1'b0;
            chk($sformatf("wrap%0d level full", w), dbg.level, 4'd8);
            chk($sformatf("wrap%0d overflow", w), dbg.overflow, 1'b1);
            for (int i = 0; i < 8; i++) begin
                dbg.rd_req = 1'b1;
                tick();
                chk($sformatf("wrap%0d rd_valid %0d", w, i), dbg.rd_valid, 1'b1);
                chk($sformatf("wrap%0d data %0d", w, i), dbg.debug_data,
                    (w == 1) ? 32'h12 + i : 32'h10 + i);
            end
            dbg.rd_req = 1'b0;
            tick();
            chk($sformatf("wrap%0d drained rd_valid", w), dbg.rd_valid, 1'b0);
            chk($sformatf("wrap%0d sticky overflow", w), dbg.overflow, 1'b1);
            dbg.relock = 1'b1;
            tick();
            dbg.relock = 1'b0;
            chk($sformatf("wrap%0d relock clears overflow", w), dbg.overflow, 1'b0);
            chk($sformatf("wrap%0d relock state", w), dbg.dbg_state, 2'b00);
        end

        // relock + unlock attempt while holding 5 entries.
        do_reset();
        unlock_now();
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1; data_in = 64'h30 + 64'(i);
            tick();
        end
        enable = 1'b0;
        chk("relock pre level", dbg.level, 4'd5);
        dbg.relock = 1'b1; dbg.unlock_valid = 1'b1; dbg.unlock_key = KEY;
        tick();
        idle();
        chk("relock+unlock state", dbg.dbg_state, 2'b00);
        chk("relock+unlock level", dbg.level, 4'd0);
        dbg.unlock_valid = 1'b1; dbg.unlock_key = 32'h0;
        tick(); tick();
        idle();
        chk("two bad keys after relock", dbg.dbg_state, 2'b00);

        // Full, drop-new: push+pop together, then reset in the middle of a read.
        do_reset();
        unlock_now();
        wrap_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            enable = 1'b1; data_in = 64'h40 + 64'(i);
            tick();
        end
        chk("full level", dbg.level, 4'd8);
        enable = 1'b1; dbg.rd_req = 1'b1; data_in = 64'h48;
        tick();
        chk("push+pop level", dbg.level, 4'd8);
        chk("push+pop overflow", dbg.overflow, 1'b0);
        chk("push+pop rd_valid", dbg.rd_valid, 1'b1);
        chk("push+pop data", dbg.debug_data, 32'h0);
        enable = 1'b0;
        tick();
        chk("second pop data", dbg.debug_data, 32'h40);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rd_valid", dbg.rd_valid, 1'b0);
        chk("async rst debug_data", dbg.debug_data, 32'h0);
        chk("async rst level", dbg.level, 4'd0);
        chk("async rst data_out", data_out, 64'h0);
        chk("async rst state", dbg.dbg_state, 2'b00);
        #1;
        rst_n = 1'b1;

        // Randomized run against the queue model, re-synchronised by periodic resets.
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                do_reset();
                model_reset();
            end
            enable           = ($urandom_range(0, 3) != 0);
            data_in          = {$urandom, $urandom};
            trace_ch         = 2'($urandom_range(0, 3));
            wrap_mode        = 1'($urandom_range(0, 1));
            dbg.unlock_valid = ($urandom_range(0, 15) == 0);
            dbg.unlock_key   = ($urandom_range(0, 3) == 0) ? 32'h1234 : KEY;
            dbg.relock       = ($urandom_range(0, 63) == 0);
            dbg.rd_req       = ($urandom_range(0, 2) == 0);
            model_edge();
            tick();
            compare_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
